sym_stream_cipher: RTL

Streaming symbol cipher built around a run-time loadable alphabet table of 2^IDX_W printable characters.
- Each accepted 8-bit character is mapped to its alphabet index and shifted by an LFSR keystream value, modulo 2^IDX_W, in encrypt or decrypt mode.
- The shifted index is mapped back to a character and presented on a valid/ready output.
- Sits between the text source and the transmit/compare logic of the LFSR cipher datapath. It replaces the fixed 32-symbol table with a parametrised, keyed, sequential engine.

---
 rtl/sym_stream_cipher_pkg.sv | 20 ++
 rtl/sym_stream_cipher_if.sv | 21 ++
 rtl/sym_stream_cipher_lfsr.sv | 32 +++
 rtl/sym_stream_cipher.sv | 116 +++++++++++
 4 files changed

// File: rtl/sym_stream_cipher_pkg.sv
// Shared constants for the symbol stream cipher: default alphabet, mode encodings, LFSR defaults.
package sym_cipher_pkg;

  localparam logic [0:31][7:0] DEFAULT_ALPHABET = "PAULBCDEFGHIJKMNOQRSTVWXYZ#&0123";

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'h0001;

  // Only the 32-entry build has a meaningful default alphabet; other sizes start blank.
  function automatic logic [7:0] reset_entry(int unsigned idx_w, int unsigned i);
    logic [4:0] ii;
    ii = i[4:0];
    if (idx_w == 5 && i < 32) return DEFAULT_ALPHABET[ii];
    return 8'h00;
  endfunction

endpackage

// File: rtl/sym_stream_cipher_if.sv
// Character stream handshake bundle: input side (source -> engine) and output side (engine -> sink).
interface sym_stream_cipher_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_ch;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_ch;
  logic       out_err;

  modport master (
    output in_valid, in_ch, mode, out_ready,
    input  in_ready, out_valid, out_ch, out_err
  );

  modport slave (
    input  in_valid, in_ch, mode, out_ready,
    output in_ready, out_valid, out_ch, out_err
  );
endinterface

// File: rtl/sym_stream_cipher_lfsr.sv
// sym_lfsr: Fibonacci LFSR with load, single step and zero-seed substitution.
module sym_lfsr #(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'h0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;
  logic              w_fb;

  assign w_fb    = ^(r_state & TAPS);
  assign o_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      // An all-zero state would lock up, so fall back to the default seed.
      r_state <= (i_seed == '0) ? SEED : i_seed;
    end else if (i_step) begin
      r_state <= {r_state[LFSR_W-2:0], w_fb};
    end
  end

endmodule

// File: rtl/sym_stream_cipher.sv
// Keyed symbol stream cipher over a loadable 2^IDX_W alphabet table.
// Optional counters enabled by SYM_STREAM_CIPHER_STATS_EN.
module sym_stream_cipher
  import sym_cipher_pkg::*;
#(
  parameter int unsigned       IDX_W  = 5,
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
  input  logic                clk,
  input  logic                rst,
  sym_stream_cipher_if.slave  bus,
  input  logic                i_seed_load,
  input  logic [LFSR_W-1:0]   i_seed,
  input  logic                i_tbl_we,
  input  logic [IDX_W-1:0]    i_tbl_addr,
  input  logic [7:0]          i_tbl_ch,
  output logic [15:0]         o_sym_count,
  output logic [15:0]         o_err_count
);

  localparam int unsigned N = 1 << IDX_W;

  logic [7:0]        r_tbl [N];
  logic              r_out_valid;
  logic [7:0]        r_out_ch;
  logic              r_out_err;

  logic              w_found;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_k;
  logic [IDX_W-1:0]  w_out_idx;
  logic [LFSR_W-1:0] w_lfsr;
  logic              w_in_ready;
  logic              w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) r_tbl[i] <= reset_entry(IDX_W, i);
    end else if (i_tbl_we) begin
      r_tbl[i_tbl_addr] <= i_tbl_ch;
    end
  end

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (r_tbl[i-1] == bus.in_ch) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(i - 1);
      end
    end
  end

  assign w_k        = w_lfsr[IDX_W-1:0];
  assign w_out_idx  = (bus.mode == MODE_DEC) ? (w_idx - w_k) : (w_idx + w_k);
  assign w_in_ready = !i_tbl_we && !i_seed_load && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  sym_lfsr #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (i_seed_load),
    .i_seed  (i_seed),
    .i_step  (w_accept && w_found),
    .o_state (w_lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= 8'h00;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_ch    <= w_found ? r_tbl[w_out_idx] : bus.in_ch;
      r_out_err   <= !w_found;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_err   = r_out_err;

`ifdef SYM_STREAM_CIPHER_STATS_EN
  logic [15:0] r_sym_count;
  logic [15:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sym_count <= 16'h0000;
      r_err_count <= 16'h0000;
    end else if (w_accept) begin
      if (w_found && r_sym_count != 16'hFFFF) r_sym_count <= r_sym_count + 16'd1;
      if (!w_found && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_sym_count = r_sym_count;
  assign o_err_count = r_err_count;
`else
  assign o_sym_count = 16'h0000;
  assign o_err_count = 16'h0000;
`endif

endmodule
